// File: rtl/parity_framer_ctrl.sv
// Byte framer: passes FRAME_LEN data bytes, then appends a parity trailer byte.
// Optional completed-frame counter enabled by defining PARITY_FRAME_CNT_EN.
module parity_framer_ctrl #(
    parameter int FRAME_LEN  = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  d_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  d_out,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready
`ifdef PARITY_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_TRAIL
    } state_t;

    localparam logic [7:0] LEN = 8'(FRAME_LEN);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic       r_acc;
    logic [7:0] r_d_out;
    logic       r_out_valid;
    logic       r_out_last;

    logic       w_out_free;
    logic       w_in_ready;
    logic       w_xfer;
    logic       w_load_trail;
    logic [7:0] w_cnt_inc;
    logic       w_frame_full;

    assign w_out_free   = !r_out_valid || out_ready;
    assign w_xfer       = in_valid && w_in_ready;
    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_frame_full = (w_cnt_inc == LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A flush with no byte taken yet in IDLE has nothing to close.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (w_frame_full || flush) begin
                        w_state_nxt = S_TRAIL;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (flush || (w_xfer && w_frame_full)) begin
                    w_state_nxt = S_TRAIL;
                end
            end
            S_TRAIL: begin
                if (w_out_free) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready   = 1'b0;
        w_load_trail = 1'b0;
        unique case (r_state)
            S_IDLE:  w_in_ready   = w_out_free;
            S_DATA:  w_in_ready   = w_out_free;
            S_TRAIL: w_load_trail = w_out_free;
            default: w_in_ready   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_out     <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_acc       <= 1'b0;
            r_cnt       <= 8'd0;
        end else if (w_xfer) begin
            r_d_out     <= d_in;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_acc       <= r_acc ^ (^d_in);
            r_cnt       <= w_cnt_inc;
        end else if (w_load_trail) begin
            r_d_out     <= {7'b0, r_acc ^ ODD_PARITY};
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_acc       <= 1'b0;
            r_cnt       <= 8'd0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

`ifdef PARITY_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'h0000;
        end else if (r_out_valid && out_ready && r_out_last) begin
            r_frame_cnt <= r_frame_cnt + 16'h0001;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign in_ready  = w_in_ready;
    assign d_out     = r_d_out;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: doc/parity_framer_ctrl.md
PARITY_FRAMER_CTRL -- requirements
Module: parity_framer_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4, data bytes per frame (legal 1..255).
REQ-002 SHALL have parameter ODD_PARITY, default 0: 0 gives even parity, 1 gives odd parity.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port d_in  input  8  upstream data byte.
REQ-006 SHALL have port in_valid  input  1  d_in valid.
REQ-007 SHALL have port in_ready  output  1  block accepts d_in this cycle.
REQ-008 SHALL have port flush  input  1  close the current frame early.
REQ-009 SHALL have port d_out  output  8  data byte or trailer byte.
REQ-010 SHALL have port out_valid  output  1  d_out valid.
REQ-011 SHALL have port out_last  output  1  d_out is the frame trailer.
REQ-012 SHALL have port out_ready  input  1  downstream accepts d_out.
REQ-013 SHALL have port frame_cnt  output  16  completed-frame count; present only under PARITY_FRAME_CNT_EN.

Function
REQ-014 SHALL implement FSM states IDLE (no bytes in frame), DATA (1..FRAME_LEN-1 bytes taken) and TRAIL (trailer pending).
REQ-015 SHALL use a single output register: it is free when out_valid=0 or out_ready=1.
REQ-016 SHALL drive in_ready = (state != TRAIL) AND output register free; combinational, no dependence on in_valid.
REQ-017 On input transfer (in_valid AND in_ready) SHALL load d_out<=d_in, out_valid<=1, out_last<=0, accumulate acc<=acc XOR (XOR-reduce d_in), cnt<=cnt+1.
REQ-018 Data latency SHALL be one cycle, from input transfer to d_out/out_valid.
REQ-019 Transitions SHALL be: IDLE->DATA on a transfer with cnt+1<FRAME_LEN; IDLE/DATA->TRAIL on the transfer that makes cnt=FRAME_LEN.
REQ-020 In TRAIL, when the output register is free, SHALL load d_out={7'b0, acc XOR ODD_PARITY}, out_valid<=1, out_last<=1, clear acc and cnt, and go to IDLE.
REQ-021 flush=1 in DATA SHALL force TRAIL next cycle; flush in IDLE with cnt=0 SHALL be ignored and SHALL emit no trailer.
REQ-022 flush coincident with an input transfer SHALL include that byte in the frame, then go to TRAIL.
REQ-023 flush in TRAIL SHALL be ignored.
REQ-024 While out_valid=1 and out_ready=0, d_out, out_valid and out_last SHALL hold stable.
REQ-025 out_valid SHALL never drop without a transfer (out_valid AND out_ready).
REQ-026 Back-to-back frames SHALL need exactly one cycle with in_ready=0 per frame (the TRAIL cycle), given out_ready held high.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, acc=0, cnt=0, d_out=8'h00, out_valid=0, out_last=0, frame_cnt=0.
REQ-028 Reset mid-frame SHALL discard the partial frame and emit no trailer for it.
REQ-029 After reset is released, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-030 Macro PARITY_FRAME_CNT_EN defined: frame_cnt SHALL increment on each trailer transfer (out_valid AND out_ready AND out_last) and wrap from 16'hFFFF to 0.
REQ-031 Macro PARITY_FRAME_CNT_EN undefined: frame_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-032 FRAME_LEN=4, out_ready=1, bytes 00,01,FF,AA -> those four bytes with out_last=0, then trailer 8'h01 with out_last=1.
REQ-033 Bytes EC,81,7F,0F -> trailer 8'h00; sent directly after REQ-032's frame, exactly one in_ready=0 cycle between frames.
REQ-034 out_ready=0 for 5 cycles while out_valid=1 -> d_out and out_last stable, in_ready=0 throughout, no byte lost or duplicated.
REQ-035 Bytes 01,03, then flush -> trailer 8'h01 after two data bytes; flush in IDLE -> no output.
REQ-036 ODD_PARITY=1, bytes 00,00,00,00 -> trailer 8'h01; rst_n pulse after 2 bytes -> no trailer, next frame's parity starts from 0.
REQ-037 With PARITY_FRAME_CNT_EN defined, 3 frames -> frame_cnt=3; counter preloaded to FFFF, one frame -> frame_cnt=0.
